// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer
//
// Fetch stage that sits after the double-buffered instruction memory. When a
// block is ready, it reads the block from address 0 upward at one read per
// cycle. A read that gets no response is issued again. Returned instructions
// go into a small registered FIFO that feeds the decoder. When the END
// instruction comes back, fetching stops and imem_rd_block_done pulses so the
// memory can swap buffers.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   start               : pulse, leaves IDLE and clears block_count
//   genesys_done        : end of program, returns WAIT to IDLE
//   imem_block_ready    : memory holds a filled block
//   imem_rd_req/addr    : read request and address (combinational)
//   imem_rd_data/valid  : response to the previous cycle's request
//   imem_rd_block_done  : one-cycle pulse after the END response
//   inst_out_*          : FIFO head towards the decoder (valid/ready handshake)
//   fetch_overflow      : sticky, read address wrapped inside a block
//   block_count         : blocks completed since start
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no program running, waiting for start
// WAIT  | waiting for the memory to report a filled block
// FETCH | streaming reads until the END instruction returns
// DONE  | single cycle, block consumed, memory may swap buffers

module instruction_fetch_sequencer #(
   parameter int         INST_DATA_WIDTH = 32,
   parameter int         INST_ADDR_WIDTH = 10,
   parameter int         FIFO_DEPTH      = 4,
   parameter logic [3:0] END_OPCODE      = 4'hF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       genesys_done,
   input  logic                       imem_block_ready,
   output logic                       imem_rd_req,
   output logic [INST_ADDR_WIDTH-1:0] imem_rd_addr,
   input  logic [INST_DATA_WIDTH-1:0] imem_rd_data,
   input  logic                       imem_rd_valid,
   output logic                       imem_rd_block_done,
   output logic                       inst_out_valid,
   output logic [INST_DATA_WIDTH-1:0] inst_out_data,
   output logic                       inst_out_last,
   input  logic                       inst_out_ready,
   output logic                       fetch_overflow,
   output logic [15:0]                block_count
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int CRD_W = CNT_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_FETCH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic [INST_ADDR_WIDTH-1:0] issue_addr_q, issue_addr_d;
   logic [INST_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                       req_q, req_d;
   logic                       fetch_overflow_q, fetch_overflow_d;
   logic [15:0]                block_count_q, block_count_d;

   logic [INST_DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
   logic                       fifo_last_q [FIFO_DEPTH];
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]           count_q, count_d;

   logic                       rsp_valid;
   logic                       miss;
   logic                       end_hit;
   logic                       push;
   logic                       pop;
   logic                       credit_ok;
   logic [CRD_W-1:0]           credit_sum;

   // A response only counts when a request was actually outstanding, so a
   // stray valid right after reset is ignored.
   assign rsp_valid = imem_rd_valid && req_q;
   assign miss      = req_q && !imem_rd_valid;
   assign end_hit   = rsp_valid &&
                      (imem_rd_data[INST_DATA_WIDTH-1 -: 4] == END_OPCODE);
   assign push      = rsp_valid;
   assign pop       = inst_out_valid && inst_out_ready;

   // The in-flight request already holds a FIFO slot. A new request is issued
   // only if its response is sure to find a free entry.
   assign credit_sum = CRD_W'(count_q) + CRD_W'(req_q) - CRD_W'(pop);
   assign credit_ok  = credit_sum < CRD_W'(FIFO_DEPTH);

   // A missed address is re-issued in the same cycle. Only one request is
   // ever outstanding, so this keeps the responses in order.
   assign imem_rd_addr = miss ? addr_q : issue_addr_q;
   assign imem_rd_req  = (state_q == S_FETCH) && !end_hit && credit_ok;

   assign imem_rd_block_done = (state_q == S_DONE);
   assign inst_out_valid     = (count_q != '0);
   assign inst_out_data      = fifo_data_q[rd_ptr_q];
   assign inst_out_last      = fifo_last_q[rd_ptr_q];
   assign fetch_overflow     = fetch_overflow_q;
   assign block_count        = block_count_q;

   always_comb begin
      state_d          = state_q;
      issue_addr_d     = issue_addr_q;
      req_d            = imem_rd_req;
      addr_d           = imem_rd_addr;
      fetch_overflow_d = fetch_overflow_q;
      block_count_d    = block_count_q;
      wr_ptr_d         = wr_ptr_q;
      rd_ptr_d         = rd_ptr_q;
      count_d          = count_q + CNT_W'(push) - CNT_W'(pop);

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d       = S_WAIT;
               block_count_d = '0;
            end
         end
         S_WAIT: begin
            if (genesys_done)          state_d = S_IDLE;
            else if (imem_block_ready) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (end_hit) begin
               state_d      = S_DONE;
               issue_addr_d = '0;
            end
         end
         S_DONE: begin
            state_d       = S_WAIT;
            block_count_d = block_count_q + 16'd1;
         end
         default: state_d = S_IDLE;
      endcase

      // A request and end_hit never happen in the same cycle, so this never
      // conflicts with the reset of issue_addr on the way to DONE.
      if (imem_rd_req) begin
         issue_addr_d = imem_rd_addr + INST_ADDR_WIDTH'(1);
         if (&imem_rd_addr) fetch_overflow_d = 1'b1;
      end else if (miss) begin
         // No credit for the retry: keep the missed address for later.
         issue_addr_d = addr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= S_IDLE;
         issue_addr_q     <= '0;
         addr_q           <= '0;
         req_q            <= 1'b0;
         fetch_overflow_q <= 1'b0;
         block_count_q    <= '0;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_q[i] <= '0;
            fifo_last_q[i] <= 1'b0;
         end
      end else begin
         state_q          <= state_d;
         issue_addr_q     <= issue_addr_d;
         addr_q           <= addr_d;
         req_q            <= req_d;
         fetch_overflow_q <= fetch_overflow_d;
         block_count_q    <= block_count_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         if (push) begin
            fifo_data_q[wr_ptr_q] <= imem_rd_data;
            fifo_last_q[wr_ptr_q] <= end_hit;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
module tb_instruction_fetch_sequencer;

   localparam int DW    = 32;
   localparam int AW    = 10;
   localparam int DEPTH = 4;
   localparam int NADDR = 1 << AW;

   logic          clk = 1'b0;
   logic          reset, start, genesys_done, imem_block_ready;
   logic          imem_rd_req, imem_rd_valid, imem_rd_block_done;
   logic [AW-1:0] imem_rd_addr;
   logic [DW-1:0] imem_rd_data, inst_out_data;
   logic          inst_out_valid, inst_out_last, inst_out_ready, fetch_overflow;
   logic [15:0]   block_count;

   always #5 clk = ~clk;

   instruction_fetch_sequencer #(
      .INST_DATA_WIDTH(DW), .INST_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .END_OPCODE(4'hF)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .genesys_done(genesys_done),
      .imem_block_ready(imem_block_ready), .imem_rd_req(imem_rd_req),
      .imem_rd_addr(imem_rd_addr), .imem_rd_data(imem_rd_data),
      .imem_rd_valid(imem_rd_valid), .imem_rd_block_done(imem_rd_block_done),
      .inst_out_valid(inst_out_valid), .inst_out_data(inst_out_data),
      .inst_out_last(inst_out_last), .inst_out_ready(inst_out_ready),
      .fetch_overflow(fetch_overflow), .block_count(block_count)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   int checks   = 0;
   int failures = 0;

   // Memory and reference model state
   logic [DW-1:0] blk [NADDR];
   bit            drop_once [NADDR];
   exp_t          exp_q [$];
   int            req_log_addr [$];
   int            req_log_cyc [$];
   int            cyc, rcv, occ, bc_model, done_seen, drop_pct, ready_mode;
   bit            pend_req, done_exp, ovf_model, blk_active, ready_drv;
   bit            start_nxt, gen_nxt;
   logic [AW-1:0] pend_addr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      pend_req   = 0;
      occ        = 0;
      exp_q.delete();
      done_exp   = 0;
      ovf_model  = 0;
      bc_model   = 0;
      blk_active = 0;
      ready_drv  = 0;
      rcv        = 0;
      for (int i = 0; i < NADDR; i++) drop_once[i] = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1; start = 0; genesys_done = 0; imem_block_ready = 0;
      imem_rd_valid = 0; imem_rd_data = '0; inst_out_ready = 0;
      @(posedge clk); #1;
      reset = 0;
      clear_model();
   endtask

   // Fill a block; END opcode at end_idx (negative: no END anywhere).
   task automatic load_block(input int end_idx);
      logic [3:0] opc;
      for (int i = 0; i < NADDR; i++) begin
         opc = 4'($urandom_range(0, 14));
         if (i == end_idx) opc = 4'hF;
         blk[i] = {opc, 28'($urandom)};
      end
      rcv = 0;
      blk_active = 1;
      ready_drv = 1;
      req_log_addr.delete();
      req_log_cyc.delete();
   endtask

   // One clock cycle: drive inputs after the edge, sample and check at negedge.
   task automatic step();
      bit   push, pop, end_now;
      exp_t e;
      @(posedge clk); #1;
      cyc++;
      start            = start_nxt;
      genesys_done     = gen_nxt;
      start_nxt        = 0;
      gen_nxt          = 0;
      imem_block_ready = ready_drv;
      imem_rd_valid    = 0;
      imem_rd_data     = '0;
      if (pend_req) begin
         if (drop_once[pend_addr]) drop_once[pend_addr] = 0;
         else if ($urandom_range(0, 99) >= drop_pct) begin
            imem_rd_valid = 1;
            imem_rd_data  = blk[pend_addr];
         end
      end
      case (ready_mode)
         0:       inst_out_ready = 0;
         1:       inst_out_ready = 1;
         default: inst_out_ready = ($urandom_range(0, 99) < 70);
      endcase
      @(negedge clk);
      push    = imem_rd_valid;
      end_now = 0;
      if (push) begin
         // The block is delivered strictly in address order.
         e.data  = blk[rcv % NADDR];
         e.last  = (e.data[DW-1 -: 4] == 4'hF);
         exp_q.push_back(e);
         end_now = (imem_rd_data[DW-1 -: 4] == 4'hF);
         rcv++;
      end
      chk("block_done", 64'(imem_rd_block_done), 64'(done_exp));
      chk("overflow", 64'(fetch_overflow), 64'(ovf_model));
      chk("block_count", 64'(block_count), 64'(bc_model));
      chk("out_valid", 64'(inst_out_valid), 64'(occ > 0));
      if (imem_rd_req) begin
         chk("req_when_active", 64'(blk_active), 64'(1));
         chk("req_addr", 64'(imem_rd_addr), 64'(rcv % NADDR));
         chk("req_on_end", 64'(end_now), 64'(0));
         req_log_addr.push_back(int'(imem_rd_addr));
         req_log_cyc.push_back(cyc);
         if (&imem_rd_addr) ovf_model = 1;
      end
      pop = inst_out_valid && inst_out_ready;
      if (pop) begin
         chk("out_pending", 64'(exp_q.size() > 0), 64'(1));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_data", 64'(inst_out_data), 64'(e.data));
            chk("out_last", 64'(inst_out_last), 64'(e.last));
         end
      end
      occ = occ + int'(push) - int'(pop);
      chk("fifo_bound", 64'(occ <= DEPTH), 64'(1));
      if (done_exp) begin
         bc_model++;
         done_seen++;
         ready_drv = 0;
      end
      if (start) bc_model = 0;
      if (end_now) blk_active = 0;
      done_exp = end_now;
      pend_req = imem_rd_req;
      pend_addr = imem_rd_addr;
   endtask

   task automatic wait_done(input int budget);
      int d0 = done_seen;
      for (int i = 0; i < budget && done_seen == d0; i++) step();
      chk("done_reached", 64'(done_seen - d0), 64'(1));
   endtask

   task automatic drain(input int budget);
      ready_mode = 1;
      for (int i = 0; i < budget && (exp_q.size() > 0 || occ > 0); i++) step();
      step();
      chk("drained", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      int exp_seq [7] = '{0, 1, 2, 2, 3, 3, 4};
      int d0;

      reset = 1; start = 0; genesys_done = 0; imem_block_ready = 0;
      imem_rd_valid = 0; imem_rd_data = '0; inst_out_ready = 0;
      cyc = 0; done_seen = 0; drop_pct = 0; ready_mode = 1;
      start_nxt = 0; gen_nxt = 0;
      clear_model();
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("rst_req", 64'(imem_rd_req), 64'(0));
      chk("rst_addr", 64'(imem_rd_addr), 64'(0));
      chk("rst_done", 64'(imem_rd_block_done), 64'(0));
      chk("rst_valid", 64'(inst_out_valid), 64'(0));
      chk("rst_data", 64'(inst_out_data), 64'(0));
      chk("rst_last", 64'(inst_out_last), 64'(0));
      chk("rst_ovf", 64'(fetch_overflow), 64'(0));
      chk("rst_bc", 64'(block_count), 64'(0));

      // Block of 5, END at address 4, decoder always ready
      start_nxt = 1;
      step();
      load_block(4);
      wait_done(50);
      chk("t1_nreq", 64'(req_log_addr.size()), 64'(5));
      if (req_log_addr.size() == 5) begin
         for (int i = 0; i < 5; i++) chk("t1_addr", 64'(req_log_addr[i]), 64'(i));
         chk("t1_span", 64'(req_log_cyc[4] - req_log_cyc[0]), 64'(4));
      end
      drain(20);
      chk("t1_bc", 64'(block_count), 64'(1));

      // Drop addresses 2 and 3 once each
      load_block(4);
      drop_once[2] = 1;
      drop_once[3] = 1;
      wait_done(50);
      chk("t2_nreq", 64'(req_log_addr.size()), 64'(7));
      if (req_log_addr.size() == 7) begin
         for (int i = 0; i < 7; i++) chk("t2_addr", 64'(req_log_addr[i]), 64'(exp_seq[i]));
         chk("t2_span", 64'(req_log_cyc[6] - req_log_cyc[0]), 64'(6));
      end
      drain(20);

      // Backpressure: decoder stalled, only DEPTH responses accepted
      load_block(9);
      ready_mode = 0;
      repeat (12) step();
      chk("t3_accepted", 64'(rcv), 64'(DEPTH));
      chk("t3_req_held", 64'(imem_rd_req), 64'(0));
      chk("t3_out_valid", 64'(inst_out_valid), 64'(1));
      ready_mode = 1;
      wait_done(60);
      drain(20);

      // genesys_done in WAIT wins over block_ready; start clears block_count
      ready_drv = 1;
      gen_nxt = 1;
      step();
      repeat (3) step();
      ready_drv = 0;
      start_nxt = 1;
      step();
      step();
      chk("t4_bc_cleared", 64'(block_count), 64'(0));

      // Back-to-back blocks, END at 2 then 6
      d0 = done_seen;
      load_block(2);
      wait_done(40);
      load_block(6);
      wait_done(40);
      chk("t4_nreq2", 64'(req_log_addr.size()), 64'(7));
      if (req_log_addr.size() > 0) chk("t4_restart", 64'(req_log_addr[0]), 64'(0));
      drain(20);
      chk("t4_pulses", 64'(done_seen - d0), 64'(2));
      chk("t4_bc", 64'(block_count), 64'(2));

      // Randomized blocks with random drops and random decoder stalls
      ready_mode = 2;
      drop_pct = 20;
      for (int b = 0; b < 15; b++) begin
         load_block($urandom_range(0, 30));
         ready_mode = 2;
         wait_done(600);
      end
      drop_pct = 0;
      drain(40);
      chk("t5_bc", 64'(block_count), 64'(17));

      // Reset in FETCH with three FIFO entries
      load_block(20);
      ready_mode = 0;
      for (int i = 0; i < 20 && occ != 3; i++) step();
      chk("t6_occ3", 64'(occ), 64'(3));
      @(posedge clk); #1;
      reset = 1;
      imem_rd_valid = pend_req;
      imem_rd_data = blk[pend_addr];
      @(posedge clk); #1;
      reset = 0;
      imem_rd_valid = 1;
      imem_rd_data = {4'h1, 28'h0ABCDEF};
      imem_block_ready = 1;
      @(negedge clk);
      chk("t6_valid0", 64'(inst_out_valid), 64'(0));
      chk("t6_req0", 64'(imem_rd_req), 64'(0));
      chk("t6_done0", 64'(imem_rd_block_done), 64'(0));
      @(posedge clk); #1;
      imem_rd_valid = 0;
      @(negedge clk);
      chk("t6_stray_ignored", 64'(inst_out_valid), 64'(0));
      chk("t6_bc0", 64'(block_count), 64'(0));
      clear_model();
      ready_drv = 1;
      repeat (3) step();
      ready_drv = 0;

      // Block without END: address wraps and overflow sticks
      start_nxt = 1;
      step();
      load_block(-1);
      ready_mode = 1;
      repeat (1040) step();
      chk("t7_overflow", 64'(fetch_overflow), 64'(1));
      chk("t7_wrapped", 64'(rcv > NADDR), 64'(1));
      do_reset();
      step();
      chk("t7_ovf_cleared", 64'(fetch_overflow), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
